// File: rtl/camera_pixel_source.sv
// rtl/camera_pixel_source.sv - camera byte pairing into RGB565 words, pixel FIFO, PIO head word
// Pixels carry sof/sol tags; software pops the head word by toggling ack_toggle.
module camera_pixel_source #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        cam_pix_en,
  input  logic        ack_toggle,
  output logic [25:0] out_port,
  output logic        overflow
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(FIFO_DEPTH);

  typedef enum logic {ST_HI, ST_LO} byte_state_t;

  byte_state_t       state;
  logic [7:0]        hi_byte;
  logic              sof_pend;
  logic              sol_pend;

  // Entry layout: {sof, sol, pixel[15:0]}
  logic [17:0]       mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [6:0]        seq;
  logic              ack_q;

  logic              byte_ok;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              accept;

  always_comb begin
    byte_ok = cam_pix_en & cam_href & ~cam_vsync;
    push    = byte_ok & (state == ST_LO);
    empty   = (count == '0);
    full    = (count == FULL_CNT);
    pop     = (ack_toggle ^ ack_q) & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    accept  = push & (~full | pop);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_HI;
      hi_byte  <= 8'h00;
      sof_pend <= 1'b1;
      sol_pend <= 1'b1;
    end else if (cam_vsync) begin
      state    <= ST_HI;
      sof_pend <= 1'b1;
      sol_pend <= 1'b1;
    end else if (!cam_href) begin
      state    <= ST_HI;
      sol_pend <= 1'b1;
    end else if (cam_pix_en) begin
      case (state)
        ST_HI: begin
          hi_byte <= cam_data;
          state   <= ST_LO;
        end
        ST_LO: begin
          sof_pend <= 1'b0;
          sol_pend <= 1'b0;
          state    <= ST_HI;
        end
        default: state <= ST_HI;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= {sof_pend, sol_pend, hi_byte, cam_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      seq      <= 7'd0;
      ack_q    <= 1'b0;
      overflow <= 1'b0;
      out_port <= 26'h0;
    end else begin
      ack_q <= ack_toggle;
      if (accept) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (push && !accept) begin
        overflow <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
        seq    <= seq + 7'd1;
      end
      case ({accept, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
      // Head word reflects the FIFO as it stood after the previous edge.
      if (empty) begin
        out_port <= {3'b000, seq, 16'h0000};
      end else begin
        out_port <= {1'b1, mem[rd_ptr][17:16], seq, mem[rd_ptr][15:0]};
      end
    end
  end

endmodule

// File: tb/tb_camera_pixel_source.sv
// tb/tb_camera_pixel_source.sv - randomized and directed bench for camera_pixel_source
// Reference model keeps the FIFO as a queue of tagged pixels.
module tb_camera_pixel_source;

  logic        clk;
  logic        reset_n;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        cam_pix_en;
  logic        ack_toggle;
  logic [25:0] out_port;
  logic        overflow;

  camera_pixel_source #(.FIFO_DEPTH(16), .ADDR_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .cam_pix_en (cam_pix_en),
    .ack_toggle (ack_toggle),
    .out_port   (out_port),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  logic [17:0] m_q[$];
  logic [6:0]  m_seq;
  logic        m_ovf;
  logic        m_ackq;
  logic        m_have_hi;
  logic [7:0]  m_hi;
  logic        m_sof;
  logic        m_sol;
  logic [25:0] m_out;
  logic        ack_lvl;
  int          pops;

  task automatic check_eq(input string tag, input logic [25:0] got, input logic [25:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic step(input logic rst_n, input logic vs, input logic hr,
                      input logic [7:0] d, input logic en, input logic ack);
    logic        do_pop;
    logic        do_push;
    logic        was_full;
    logic [17:0] pix;
    reset_n = rst_n; cam_vsync = vs; cam_href = hr; cam_data = d;
    cam_pix_en = en; ack_toggle = ack;
    pix = '0;
    if (!rst_n) begin
      m_q.delete();
      m_seq = 0; m_ovf = 0; m_ackq = 0; m_have_hi = 0; m_hi = 0;
      m_sof = 1; m_sol = 1; m_out = 26'h0;
    end else begin
      if (m_q.size() != 0) m_out = {1'b1, m_q[0][17:16], m_seq, m_q[0][15:0]};
      else                 m_out = {3'b000, m_seq, 16'h0};
      do_pop   = (ack != m_ackq) && (m_q.size() != 0);
      was_full = (m_q.size() == 16);
      do_push  = 0;
      if (vs) begin
        m_have_hi = 0; m_sof = 1; m_sol = 1;
      end else if (!hr) begin
        m_have_hi = 0; m_sol = 1;
      end else if (en) begin
        if (!m_have_hi) begin
          m_hi = d; m_have_hi = 1;
        end else begin
          do_push = 1; pix = {m_sof, m_sol, m_hi, d};
          m_sof = 0; m_sol = 0; m_have_hi = 0;
        end
      end
      if (do_pop) begin
        void'(m_q.pop_front());
        m_seq = m_seq + 7'd1;
        pops++;
      end
      if (do_push) begin
        if (!was_full || do_pop) m_q.push_back(pix);
        else m_ovf = 1;
      end
      m_ackq = ack;
    end
    @(posedge clk);
    #1;
    check_eq("out_port", out_port, m_out);
    check_eq("overflow", {25'h0, overflow}, {25'h0, m_ovf});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 1, 8'h00, 0, ack_lvl);
  endtask

  task automatic byte_in(input logic [7:0] d);
    step(1, 0, 1, d, 1, ack_lvl);
  endtask

  task automatic pop_one();
    ack_lvl = ~ack_lvl;
    step(1, 0, 1, 8'h00, 0, ack_lvl);
  endtask

  task automatic do_reset();
    ack_lvl = 0;
    step(0, 0, 0, 8'h00, 0, 0);
    step(0, 0, 0, 8'h00, 0, 0);
  endtask

  initial begin
    n_vec = 0; n_err = 0; pops = 0; ack_lvl = 0;
    reset_n = 0; cam_vsync = 0; cam_href = 0; cam_data = 0; cam_pix_en = 0; ack_toggle = 0;

    do_reset();
    check_eq("reset_out", out_port, 26'h0);

    // Frame start, first pixel
    step(1, 1, 0, 8'h00, 0, 0);
    byte_in(8'hA1);
    byte_in(8'hB2);
    idle(1);
    check_eq("t1_first_word", out_port, {1'b1, 1'b1, 1'b1, 7'd0, 16'hA1B2});

    byte_in(8'h33);
    byte_in(8'h44);
    pop_one();
    idle(1);
    check_eq("t2_second_word", out_port, {1'b1, 1'b0, 1'b0, 7'd1, 16'h3344});
    pop_one();
    idle(1);
    check_eq("t2_empty", out_port, {3'b000, 7'd2, 16'h0});

    // Odd trailing byte is dropped at end of line
    step(1, 0, 0, 8'h00, 0, ack_lvl);
    byte_in(8'h11); byte_in(8'h22); byte_in(8'h33);
    step(1, 0, 0, 8'h00, 0, ack_lvl);
    byte_in(8'h44); byte_in(8'h55);
    idle(1);
    check_eq("t3_line1", out_port, {1'b1, 1'b0, 1'b1, 7'd2, 16'h1122});
    pop_one(); idle(1);
    check_eq("t3_line2", out_port, {1'b1, 1'b0, 1'b1, 7'd3, 16'h4455});
    pop_one(); idle(1);
    check_eq("t3_empty", out_port, {3'b000, 7'd4, 16'h0});

    // Overflow on the 17th pixel
    do_reset();
    step(1, 1, 0, 8'h00, 0, 0);
    for (int i = 1; i <= 17; i++) begin
      byte_in(8'h00); byte_in(8'(i));
    end
    idle(1);
    check_eq("t4_overflow", {25'h0, overflow}, 26'h1);
    for (int i = 1; i <= 16; i++) begin
      idle(1);
      check_eq("t4_pop_pixel", {10'h0, out_port[15:0]}, {10'h0, 8'h00, 8'(i)});
      pop_one();
    end
    idle(1);
    check_eq("t4_drained", {25'h0, out_port[25]}, 26'h0);

    // Push and pop together on a full FIFO
    do_reset();
    step(1, 1, 0, 8'h00, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      byte_in(8'hC0); byte_in(8'(i));
    end
    byte_in(8'hD0);
    ack_lvl = ~ack_lvl;
    byte_in(8'h99);
    idle(1);
    check_eq("t5_no_overflow", {25'h0, overflow}, 26'h0);
    check_eq("t5_head", {10'h0, out_port[15:0]}, {10'h0, 16'hC002});
    for (int i = 0; i < 16; i++) pop_one();
    idle(1);
    check_eq("t5_sixteen_left", out_port, {3'b000, 7'd17, 16'h0});

    // Ack while empty leaves seq alone
    pop_one(); pop_one();
    idle(1);
    check_eq("t6_empty_ack", out_port, {3'b000, 7'd17, 16'h0});

    // Randomized traffic in phases of varying ack pressure
    pops = 0;
    for (int ph = 0; ph < 16; ph++) begin
      int ack_pct;
      ack_pct = (ph % 4 == 0) ? 0 : (ph % 4 == 1) ? 10 : (ph % 4 == 2) ? 50 : 90;
      for (int c = 0; c < 250; c++) begin
        logic vs, hr, en;
        vs = ($urandom_range(99) == 0);
        hr = ($urandom_range(19) != 0);
        en = ($urandom_range(99) < 60);
        if ($urandom_range(99) < ack_pct) ack_lvl = ~ack_lvl;
        step(1, vs, hr, 8'($urandom), en, ack_lvl);
      end
    end
    while (m_q.size() != 0) pop_one();
    idle(1);
    check_eq("rand_pops_gt128", {25'h0, pops > 128}, 26'h1);

    // 128 pops wrap seq back to its starting value
    begin
      logic [6:0] seq0;
      seq0 = m_seq;
      for (int i = 0; i < 128; i++) begin
        byte_in(8'($urandom)); byte_in(8'($urandom));
        idle(1);
        pop_one();
      end
      idle(1);
      check_eq("seq_wrap", {19'h0, out_port[22:16]}, {19'h0, seq0});
    end

    // Reset mid-pixel: no stray word afterwards
    byte_in(8'h5A);
    do_reset();
    byte_in(8'hA5);
    idle(2);
    check_eq("reset_mid_pixel", out_port, 26'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
